// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes, FSM encoding
// and iteration count.
package hilo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 2 * DATA_W;
  localparam int unsigned FUN_W  = 6;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = $clog2(ITERS);

  localparam logic [FUN_W-1:0] FUN_MTHI  = 6'h11;
  localparam logic [FUN_W-1:0] FUN_MTLO  = 6'h13;
  localparam logic [FUN_W-1:0] FUN_MULT  = 6'h18;
  localparam logic [FUN_W-1:0] FUN_MULTU = 6'h19;
  localparam logic [FUN_W-1:0] FUN_DIV   = 6'h1A;
  localparam logic [FUN_W-1:0] FUN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-stage HI/LO access bundle between the pipeline front-end (master) and the
// multiply/divide unit (slave).
interface hilo_muldiv_if;
  import hilo_pkg::*;

  logic              iHiLoWrite;
  logic [FUN_W-1:0]  iFun;
  logic [DATA_W-1:0] iRegOut1;
  logic [DATA_W-1:0] iRegOut2;
  logic              iRead;
  logic              iHL;
  logic [DATA_W-1:0] oResult;
  logic [DATA_W-1:0] oHi;
  logic [DATA_W-1:0] oLo;
  logic              oBusy;
  logic              oStall;

  modport master (
    output iHiLoWrite, iFun, iRegOut1, iRegOut2, iRead, iHL,
    input  oResult, oHi, oLo, oBusy, oStall
  );

  modport slave (
    input  iHiLoWrite, iFun, iRegOut1, iRegOut2, iRead, iHL,
    output oResult, oHi, oLo, oBusy, oStall
  );

endinterface

// File: rtl/hilo_div_step.sv
// One restoring-divide iteration on unsigned magnitudes. The partial remainder
// is always below the divisor, so its top bit stands in for the shifted-out bit.
module hilo_div_step
  import hilo_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic [DATA_W-1:0] quo_nxt
);

  logic [DATA_W-1:0] shl;
  logic              ge;

  // A set rem MSB means the 33-bit shifted value already exceeds any divisor.
  assign shl     = {rem[DATA_W-2:0], quo[DATA_W-1]};
  assign ge      = rem[DATA_W-1] | (shl >= divisor);
  assign rem_nxt = ge ? (shl - divisor) : shl;
  assign quo_nxt = {quo[DATA_W-2:0], ge};

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO and MFHI/MFLO read port.
// Divider compiled in only when HILO_DIV_EN is defined.
module hilo_muldiv
  import hilo_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave hilo
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;

  logic              op_signed, a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W:0]   mul_sum;
  logic [ACC_W-1:0]  prod;

`ifdef HILO_DIV_EN
  logic              rsign_q, rsign_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rem_nxt, quo_nxt;

  hilo_div_step u_div_step (
    .rem     (acc_q[ACC_W-1:DATA_W]),
    .quo     (acc_q[DATA_W-1:0]),
    .divisor (opb_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );
`endif

  // Operand magnitudes and sign flags for the op presented this cycle
  assign op_signed = (hilo.iFun == FUN_MULT) || (hilo.iFun == FUN_DIV);
  assign a_neg     = op_signed & hilo.iRegOut1[DATA_W-1];
  assign b_neg     = op_signed & hilo.iRegOut2[DATA_W-1];
  assign mag_a     = a_neg ? (~hilo.iRegOut1 + DATA_W'(1)) : hilo.iRegOut1;
  assign mag_b     = b_neg ? (~hilo.iRegOut2 + DATA_W'(1)) : hilo.iRegOut2;

  // Shift-add: acc holds {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign prod    = sign_q ? (~acc_q + ACC_W'(1)) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef HILO_DIV_EN
    rsign_d = rsign_q;
    div_d   = div_q;
    dz_d    = dz_q;
    rs_d    = rs_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (hilo.iHiLoWrite) begin
          case (hilo.iFun)
            FUN_MULT, FUN_MULTU: begin
              state_d = ST_MUL;
              acc_d   = {DATA_W'(0), mag_b};
              opb_d   = mag_a;
              cnt_d   = '0;
              sign_d  = a_neg ^ b_neg;
`ifdef HILO_DIV_EN
              div_d   = 1'b0;
`endif
            end
`ifdef HILO_DIV_EN
            FUN_DIV, FUN_DIVU: begin
              state_d = ST_DIV;
              acc_d   = {DATA_W'(0), mag_a};
              opb_d   = mag_b;
              cnt_d   = '0;
              sign_d  = a_neg ^ b_neg;
              rsign_d = a_neg;
              div_d   = 1'b1;
              dz_d    = (hilo.iRegOut2 == '0);
              rs_d    = hilo.iRegOut1;
            end
`endif
            FUN_MTHI: hi_d = hilo.iRegOut1;
            FUN_MTLO: lo_d = hilo.iRegOut1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
      end
`ifdef HILO_DIV_EN
      ST_DIV: begin
        acc_d = {rem_nxt, quo_nxt};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
      end
`endif
      ST_FIX: begin
        state_d = ST_IDLE;
        hi_d    = prod[ACC_W-1:DATA_W];
        lo_d    = prod[DATA_W-1:0];
`ifdef HILO_DIV_EN
        // Divide-by-zero overrides the iterated result with fixed values
        if (div_q) begin
          if (dz_q) begin
            hi_d = rs_q;
            lo_d = '1;
          end else begin
            hi_d = rsign_q ? (~acc_q[ACC_W-1:DATA_W] + DATA_W'(1)) : acc_q[ACC_W-1:DATA_W];
            lo_d = sign_q  ? (~acc_q[DATA_W-1:0] + DATA_W'(1))     : acc_q[DATA_W-1:0];
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef HILO_DIV_EN
      rsign_q <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      rs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef HILO_DIV_EN
      rsign_q <= rsign_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      rs_q    <= rs_d;
`endif
    end
  end

  assign hilo.oHi     = hi_q;
  assign hilo.oLo     = lo_q;
  assign hilo.oBusy   = (state_q != ST_IDLE);
  assign hilo.oResult = hilo.iHL ? hi_q : lo_q;
  assign hilo.oStall  = hilo.oBusy & (hilo.iHiLoWrite | hilo.iRead);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized self-checking bench for hilo_muldiv against an arithmetic HI/LO model.
// Honours HILO_DIV_EN the same way the design does.
module tb_hilo_muldiv;
  import hilo_pkg::*;

`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  hilo_muldiv_if hif ();

  hilo_muldiv u_dut (
    .clk  (clk),
    .rst  (rst),
    .hilo (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of an op given the current HI/LO: {hi, lo}
  function automatic logic [63:0] ref_op(input logic [5:0] fun, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    logic [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    r  = {hi, lo};
    case (fun)
      FUN_MULT:  r = 64'(sa * sb);
      FUN_MULTU: r = {32'd0, a} * {32'd0, b};
      FUN_DIV: if (DIV_EN) begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(qa % qb), 32'(qa / qb)};
      end
      FUN_DIVU: if (DIV_EN) begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      FUN_MTHI:  r = {a, lo};
      FUN_MTLO:  r = {hi, a};
      default:   r = {hi, lo};
    endcase
    return r;
  endfunction

  function automatic bit is_iter(input logic [5:0] fun);
    return (fun == FUN_MULT) || (fun == FUN_MULTU) ||
           (DIV_EN && ((fun == FUN_DIV) || (fun == FUN_DIVU)));
  endfunction

  // Issue one op; while busy optionally present MFLO (rd) and a rogue MTHI (poke)
  task automatic do_op(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                       input bit rd, input bit poke);
    logic [63:0] exp;
    int n;
    exp = ref_op(fun, a, b, exp_hi, exp_lo);
    @(negedge clk);
    hif.iHiLoWrite = 1'b1;
    hif.iFun       = fun;
    hif.iRegOut1   = a;
    hif.iRegOut2   = b;
    hif.iRead      = 1'b0;
    @(posedge clk);
    #1;
    hif.iHiLoWrite = 1'b0;
    hif.iRegOut1   = $urandom;
    hif.iRegOut2   = $urandom;
    if (is_iter(fun)) begin
      check_eq("busy_start", 32'(hif.oBusy), 32'd1);
      n = 0;
      while (n < 60) begin
        if (!hif.oBusy) break;
        n++;
        hif.iRead = rd;
        hif.iHL   = 1'b0;
        if (poke) begin
          hif.iHiLoWrite = 1'b1;
          hif.iFun       = FUN_MTHI;
          hif.iRegOut1   = $urandom;
        end
        #1;
        check_eq("stall", 32'(hif.oStall), 32'(rd | poke));
        check_eq("hi_hold", hif.oHi, exp_hi);
        check_eq("lo_hold", hif.oLo, exp_lo);
        @(posedge clk);
        #1;
      end
      hif.iRead      = 1'b0;
      hif.iHiLoWrite = 1'b0;
      check_eq("busy_cycles", 32'(n), 32'd33);
    end else begin
      check_eq("busy_none", 32'(hif.oBusy), 32'd0);
    end
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    check_eq("hi", hif.oHi, exp_hi);
    check_eq("lo", hif.oLo, exp_lo);
    hif.iHL   = 1'b1;
    hif.iRead = 1'b1;
    #1;
    check_eq("result_hi", hif.oResult, exp_hi);
    check_eq("stall_idle", 32'(hif.oStall), 32'd0);
    hif.iHL = 1'b0;
    #1;
    check_eq("result_lo", hif.oResult, exp_lo);
    hif.iRead = 1'b0;
  endtask

  logic [5:0] fun_tab [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    fun_tab  = '{FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO, 6'h10, 6'h00};
    rst            = 1'b1;
    hif.iHiLoWrite = 1'b0;
    hif.iFun       = 6'h00;
    hif.iRegOut1   = 32'd0;
    hif.iRegOut2   = 32'd0;
    hif.iRead      = 1'b1;
    hif.iHL        = 1'b0;
    #3;
    check_eq("rst_hi", hif.oHi, 32'd0);
    check_eq("rst_lo", hif.oLo, 32'd0);
    check_eq("rst_result", hif.oResult, 32'd0);
    check_eq("rst_busy", 32'(hif.oBusy), 32'd0);
    check_eq("rst_stall", 32'(hif.oStall), 32'd0);
    hif.iRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_op(FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("multu_max_hi", hif.oHi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo", hif.oLo, 32'h0000_0001);
    do_op(FUN_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    check_eq("mult_neg_hi", hif.oHi, 32'hFFFF_FFFF);
    check_eq("mult_neg_res", hif.oResult, 32'hFFFF_FFEB);
`ifdef HILO_DIV_EN
    do_op(FUN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    check_eq("div_neg_lo", hif.oLo, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hif.oHi, 32'hFFFF_FFFF);
    do_op(FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("div_ovf_lo", hif.oLo, 32'h8000_0000);
    check_eq("div_ovf_hi", hif.oHi, 32'h0000_0000);
    do_op(FUN_DIVU, 32'd100, 32'd0, 1'b1, 1'b1);
    check_eq("divz_lo", hif.oLo, 32'hFFFF_FFFF);
    check_eq("divz_hi", hif.oHi, 32'h0000_0064);
    do_op(FUN_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
`else
    do_op(FUN_DIVU, 32'd10, 32'd2, 1'b0, 1'b0);
    check_eq("nodiv_lo", hif.oLo, 32'hFFFF_FFEB);
    check_eq("nodiv_hi", hif.oHi, 32'hFFFF_FFFF);
`endif
    do_op(FUN_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    check_eq("mthi", hif.oHi, 32'h1234_5678);
    do_op(FUN_MTLO, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    hif.iHiLoWrite = 1'b1;
    hif.iFun       = FUN_MULTU;
    hif.iRegOut1   = 32'd5;
    hif.iRegOut2   = 32'd5;
    @(posedge clk);
    #1;
    hif.iHiLoWrite = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(hif.oBusy), 32'd0);
    check_eq("midrst_hi", hif.oHi, 32'd0);
    check_eq("midrst_lo", hif.oLo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    do_op(FUN_MULTU, 32'd2, 32'd3, 1'b0, 1'b0);
    check_eq("after_rst_lo", hif.oLo, 32'd6);

    for (int i = 0; i < 24; i++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      f = fun_tab[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
      do_op(f, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
